// File: rtl/l2_wrr_arbiter_pkg.sv
// Shared request types and the {port, sub_id} transaction-ID layout for the
// L2 weighted round-robin arbiter and its port-search helper.
package l2_config_and_types;

  localparam int unsigned L2_ADDR_W    = 30;
  localparam int unsigned L2_BURST_W   = 5;
  localparam int unsigned L2_DATA_W    = 32;
  localparam int unsigned L2_NUM_PORTS = 4;
  localparam int unsigned L2_SUB_ID_W  = 2;

  function automatic int unsigned l2_port_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned PORT_W = l2_port_w(L2_NUM_PORTS);
  localparam int unsigned ID_W   = PORT_W + L2_SUB_ID_W;

  typedef struct packed {
    logic [L2_ADDR_W-1:0]   addr;
    logic                   rnw;
    logic [L2_BURST_W-1:0]  burst;
    logic [L2_SUB_ID_W-1:0] sub_id;
  } l2_wrr_request_t;

  // sub_id travels inside id as its low field
  typedef struct packed {
    logic [L2_ADDR_W-1:0]  addr;
    logic                  rnw;
    logic [L2_BURST_W-1:0] burst;
    logic [ID_W-1:0]       id;
  } l2_wrr_mem_request_t;

endpackage

// File: rtl/l2_wrr_arbiter_select.sv
// Circular first-eligible search starting strictly after i_ptr; the pointer
// port itself is considered last.
module l2_wrr_select
  import l2_config_and_types::*;
#(
  parameter int unsigned NUM_PORTS = L2_NUM_PORTS
) (
  input  logic [NUM_PORTS-1:0] i_eligible,
  input  logic [PORT_W-1:0]    i_ptr,
  output logic [PORT_W-1:0]    o_grant,
  output logic                 o_any
);

  always_comb begin
    logic        found;
    int unsigned idx;
    found   = 1'b0;
    idx     = 0;
    o_grant = i_ptr;
    o_any   = |i_eligible;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx = (32'(i_ptr) + k) % NUM_PORTS;
      if (!found && i_eligible[idx[PORT_W-1:0]]) begin
        o_grant = idx[PORT_W-1:0];
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_wrr_arbiter.sv
// Weighted round-robin L2 request arbiter with per-port read credits and
// return demux by ID. Optional perf counters: L2_ARB_PERF_COUNTERS_EN.
module l2_wrr_arbiter
  import l2_config_and_types::*;
#(
  parameter int unsigned NUM_PORTS       = L2_NUM_PORTS,
  parameter int unsigned SUB_ID_W        = L2_SUB_ID_W,
  parameter int unsigned WEIGHT_W        = 3,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            i_req_valid,
  output logic [NUM_PORTS-1:0]            o_req_ready,
  input  logic [NUM_PORTS*L2_ADDR_W-1:0]  i_req_addr,
  input  logic [NUM_PORTS-1:0]            i_req_rnw,
  input  logic [NUM_PORTS*L2_BURST_W-1:0] i_req_burst,
  input  logic [NUM_PORTS*SUB_ID_W-1:0]   i_req_sub_id,
  input  logic [NUM_PORTS*WEIGHT_W-1:0]   i_port_weight,
  output logic                            o_mem_valid,
  input  logic                            i_mem_ready,
  output logic [L2_ADDR_W-1:0]            o_mem_addr,
  output logic                            o_mem_rnw,
  output logic [L2_BURST_W-1:0]           o_mem_burst,
  output logic [ID_W-1:0]                 o_mem_id,
  input  logic                            i_rd_valid,
  input  logic [ID_W-1:0]                 i_rd_id,
  input  logic                            i_rd_last,
  input  logic [L2_DATA_W-1:0]            i_rd_data,
  output logic [NUM_PORTS-1:0]            o_ret_valid,
  output logic [SUB_ID_W-1:0]             o_ret_sub_id,
  output logic [L2_DATA_W-1:0]            o_ret_data
`ifdef L2_ARB_PERF_COUNTERS_EN
  ,
  output logic [NUM_PORTS*32-1:0]         o_perf_grants,
  output logic [NUM_PORTS*32-1:0]         o_perf_credit_stalls
`endif
);

  localparam int unsigned       CRED_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_OUTSTANDING);

  // The ID layout lives in the package, so the port/sub-ID split must agree with it
  if (l2_port_w(NUM_PORTS) != PORT_W || SUB_ID_W != L2_SUB_ID_W) begin : g_bad_cfg
    $error("l2_wrr_arbiter: NUM_PORTS/SUB_ID_W disagree with l2_config_and_types ID layout");
  end

  l2_wrr_request_t     w_req [NUM_PORTS];
  logic [WEIGHT_W-1:0] w_weff [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_elig, w_inc, w_dec;
  logic [WEIGHT_W-1:0] w_cur_w;
  logic                w_keep, w_any, w_load, w_accept;
  logic [PORT_W-1:0]   w_sel_grant, w_grant, w_rd_port;
  l2_wrr_mem_request_t w_next;

  logic [PORT_W-1:0]   r_ptr;
  logic [WEIGHT_W-1:0] r_turn, r_cur_w;
  logic [CRED_W-1:0]   r_cred [NUM_PORTS];
  logic                r_mem_valid;
  l2_wrr_mem_request_t r_mem;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_req[i].addr   = i_req_addr[i*L2_ADDR_W +: L2_ADDR_W];
      w_req[i].rnw    = i_req_rnw[i];
      w_req[i].burst  = i_req_burst[i*L2_BURST_W +: L2_BURST_W];
      w_req[i].sub_id = i_req_sub_id[i*SUB_ID_W +: SUB_ID_W];
      w_weff[i] = (i_port_weight[i*WEIGHT_W +: WEIGHT_W] == '0) ?
                  WEIGHT_W'(1) : i_port_weight[i*WEIGHT_W +: WEIGHT_W];
      w_elig[i] = i_req_valid[i] & (~i_req_rnw[i] | (r_cred[i] < CRED_MAX));
    end
  end

  l2_wrr_select #(.NUM_PORTS(NUM_PORTS)) u_select (
    .i_eligible (w_elig),
    .i_ptr      (r_ptr),
    .o_grant    (w_sel_grant),
    .o_any      (w_any)
  );

  assign w_rd_port = i_rd_id[ID_W-1:SUB_ID_W];

  // Weight is latched when a turn starts; turn==0 only occurs straight out of reset
  always_comb begin
    w_cur_w  = (r_turn == '0) ? w_weff[r_ptr] : r_cur_w;
    w_keep   = w_elig[r_ptr] & (r_turn < w_cur_w);
    w_grant  = w_keep ? r_ptr : w_sel_grant;
    w_load   = ~r_mem_valid | i_mem_ready;
    w_accept = w_load & w_any & ~rst;
    o_req_ready          = '0;
    o_req_ready[w_grant] = w_accept;
    w_next.addr  = w_req[w_grant].addr;
    w_next.rnw   = w_req[w_grant].rnw;
    w_next.burst = w_req[w_grant].burst;
    w_next.id    = {w_grant, w_req[w_grant].sub_id};
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_inc[i]       = w_accept & (w_grant == PORT_W'(i)) & i_req_rnw[i];
      w_dec[i]       = i_rd_valid & i_rd_last & (w_rd_port == PORT_W'(i));
      o_ret_valid[i] = i_rd_valid & (w_rd_port == PORT_W'(i)) & ~rst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_turn      <= '0;
      r_cur_w     <= '0;
      r_mem_valid <= 1'b0;
      r_mem       <= '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) r_cred[i] <= '0;
    end else begin
      if (w_accept) begin
        r_mem_valid <= 1'b1;
        r_mem       <= w_next;
        if (w_keep) begin
          r_turn  <= r_turn + 1'b1;
          r_cur_w <= w_cur_w;
        end else begin
          r_ptr   <= w_grant;
          r_turn  <= WEIGHT_W'(1);
          r_cur_w <= w_weff[w_grant];
        end
      end else if (i_mem_ready) begin
        r_mem_valid <= 1'b0;
      end
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (w_inc[i] & ~w_dec[i])
          r_cred[i] <= r_cred[i] + 1'b1;
        else if (w_dec[i] & ~w_inc[i] & (r_cred[i] != '0))
          r_cred[i] <= r_cred[i] - 1'b1;
      end
    end
  end

  assign o_mem_valid  = r_mem_valid;
  assign o_mem_addr   = r_mem.addr;
  assign o_mem_rnw    = r_mem.rnw;
  assign o_mem_burst  = r_mem.burst;
  assign o_mem_id     = r_mem.id;
  assign o_ret_sub_id = i_rd_id[SUB_ID_W-1:0];
  assign o_ret_data   = i_rd_data;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cred_chk
    a_cred_underflow: assert property (@(posedge clk) disable iff (rst)
      !(w_dec[gi] && !w_inc[gi] && r_cred[gi] == '0));
  end

  a_rd_port_range: assert property (@(posedge clk) disable iff (rst)
    !(i_rd_valid && (int'(w_rd_port) >= int'(NUM_PORTS))));

`ifdef L2_ARB_PERF_COUNTERS_EN
  logic [31:0] r_perf_grants [NUM_PORTS];
  logic [31:0] r_perf_stalls [NUM_PORTS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        r_perf_grants[i] <= '0;
        r_perf_stalls[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (o_req_ready[i])
          r_perf_grants[i] <= r_perf_grants[i] + 32'd1;
        if (i_req_valid[i] & i_req_rnw[i] & (r_cred[i] == CRED_MAX))
          r_perf_stalls[i] <= r_perf_stalls[i] + 32'd1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      o_perf_grants[i*32 +: 32]        = r_perf_grants[i];
      o_perf_credit_stalls[i*32 +: 32] = r_perf_stalls[i];
    end
  end
`endif

endmodule

// File: tb/tb_l2_wrr_arbiter.sv
// Directed bench for l2_wrr_arbiter: per-cycle comparison against a
// queue/array model plus literal grant-sequence and boundary expectations.
module tb_l2_wrr_arbiter;

  localparam int NP = 4, SW = 2, WW = 3, MAXO = 4, IDW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]    req_valid, req_ready, req_rnw;
  logic [NP*30-1:0] req_addr;
  logic [NP*5-1:0]  req_burst;
  logic [NP*SW-1:0] req_sub_id;
  logic [NP*WW-1:0] port_weight;
  logic             mem_valid, mem_ready, mem_rnw;
  logic [29:0]      mem_addr;
  logic [4:0]       mem_burst;
  logic [IDW-1:0]   mem_id;
  logic             rd_valid, rd_last;
  logic [IDW-1:0]   rd_id;
  logic [31:0]      rd_data;
  logic [NP-1:0]    ret_valid;
  logic [SW-1:0]    ret_sub_id;
  logic [31:0]      ret_data;

  l2_wrr_arbiter #(
    .NUM_PORTS(NP), .SUB_ID_W(SW), .WEIGHT_W(WW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .i_req_rnw(req_rnw), .i_req_burst(req_burst), .i_req_sub_id(req_sub_id),
    .i_port_weight(port_weight),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
    .o_mem_rnw(mem_rnw), .o_mem_burst(mem_burst), .o_mem_id(mem_id),
    .i_rd_valid(rd_valid), .i_rd_id(rd_id), .i_rd_last(rd_last), .i_rd_data(rd_data),
    .o_ret_valid(ret_valid), .o_ret_sub_id(ret_sub_id), .o_ret_data(ret_data)
  );

  int total = 0;
  int bad   = 0;
  int g_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string nm, input int n, input logic [63:0] exp);
    logic [63:0] v;
    v = '0;
    chk({nm, "_len"}, 64'(g_log.size()), 64'(n));
    for (int i = 0; i < g_log.size() && i < 16; i++) v = (v << 4) | 64'(g_log[i]);
    chk(nm, v, exp);
  endtask

  // Model: owner holds the turn while eligible with grants left, else next eligible in ring order
  int          m_owner, m_left;
  bit          m_fresh, m_mv, m_rnw;
  logic [29:0] m_addr;
  logic [4:0]  m_burst;
  logic [3:0]  m_id;
  int          m_cred[NP];

  function automatic int weff(input int p);
    int w;
    w = int'(port_weight[p*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  always @(negedge clk) begin
    logic [NP-1:0] el, exp_ready, exp_ret;
    logic [1:0]    gp;
    int            left, g, rp;
    bit            found, load;
    if (rst) begin
      chk("rst_mem_valid", 64'(mem_valid), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_mem_id", 64'(mem_id), 64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_ret_valid", 64'(ret_valid), 64'(0));
      m_owner = 0; m_left = 0; m_fresh = 1'b1; m_mv = 1'b0;
      m_addr = '0; m_rnw = 1'b0; m_burst = '0; m_id = '0;
      for (int i = 0; i < NP; i++) m_cred[i] = 0;
    end else begin
      for (int i = 0; i < NP; i++) el[i] = req_valid[i] && (!req_rnw[i] || m_cred[i] < MAXO);
      left = m_fresh ? weff(m_owner) : m_left;
      g = m_owner;
      if (!(el[m_owner] && left > 0)) begin
        found = 1'b0;
        for (int k = 1; k <= NP; k++)
          if (!found && el[(m_owner + k) % NP]) begin g = (m_owner + k) % NP; found = 1'b1; end
      end
      load      = !m_mv || mem_ready;
      exp_ready = (load && |el) ? NP'(1) << g : '0;
      rp        = int'(rd_id[3:2]);
      exp_ret   = rd_valid ? NP'(1) << rp : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("mem_valid", 64'(mem_valid), 64'(m_mv));
      if (m_mv) begin
        chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        chk("mem_rnw", 64'(mem_rnw), 64'(m_rnw));
        chk("mem_burst", 64'(mem_burst), 64'(m_burst));
        chk("mem_id", 64'(mem_id), 64'(m_id));
      end
      chk("ret_valid", 64'(ret_valid), 64'(exp_ret));
      if (rd_valid) begin
        chk("ret_sub_id", 64'(ret_sub_id), 64'(rd_id[1:0]));
        chk("ret_data", 64'(ret_data), 64'(rd_data));
      end
      for (int i = 0; i < NP; i++) if (req_ready[i]) g_log.push_back(i);
      if (load) begin
        if (|el) begin
          gp      = 2'(g);
          m_mv    = 1'b1;
          m_addr  = req_addr[g*30 +: 30];
          m_rnw   = req_rnw[g];
          m_burst = req_burst[g*5 +: 5];
          m_id    = {gp, req_sub_id[g*SW +: SW]};
          if (g == m_owner && el[m_owner] && left > 0) m_left = left - 1;
          else begin m_owner = g; m_left = weff(g) - 1; end
          m_fresh = 1'b0;
          if (req_rnw[g]) m_cred[g]++;
        end else begin
          m_mv = 1'b0;
        end
      end
      if (rd_valid && rd_last && m_cred[rp] > 0) m_cred[rp]--;
    end
  end

  task automatic set_port(input int p, input bit v, input bit rnw);
    req_valid[p] = v;
    req_rnw[p]   = rnw;
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    port_weight = {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
  endtask

  task automatic all_ports(input bit v, input bit rnw);
    for (int p = 0; p < NP; p++) set_port(p, v, rnw);
  endtask

  task automatic rst_on();
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic rst_off();
    @(posedge clk); #1 rst = 1'b0;
    g_log.delete();
  endtask

  initial begin
    req_valid = '0; req_rnw = '0; mem_ready = 1'b1;
    rd_valid = 1'b0; rd_last = 1'b0; rd_id = '0; rd_data = '0;
    for (int p = 0; p < NP; p++) begin
      req_addr[p*30 +: 30] = 30'h2000 + 30'(p);
      req_burst[p*5 +: 5]  = 5'(p + 1);
      req_sub_id[p*SW +: SW] = SW'(p);
    end
    set_w(1, 1, 1, 1);

    // Reset: requests pending but nothing may be accepted
    repeat (2) @(posedge clk);
    #1 all_ports(1'b1, 1'b0);
    #1 chk("lit_rst_ready", 64'(req_ready), 64'(0));
    chk("lit_rst_mvalid", 64'(mem_valid), 64'(0));

    // Equal weights, continuous writes
    rst_off();
    repeat (8) @(posedge clk);
    #1 chk_log("lit_wrr_equal", 8, 64'h01230123);

    // Weights {3,1,0,2}
    rst_on();
    set_w(3, 1, 0, 2);
    rst_off();
    repeat (10) @(posedge clk);
    #1 chk_log("lit_wrr_weighted", 10, 64'h0001233000);

    // Credit cap on port 1 reads
    rst_on();
    set_w(1, 1, 1, 1);
    all_ports(1'b0, 1'b0);
    set_port(1, 1'b1, 1'b1);
    rst_off();
    repeat (6) @(posedge clk);
    #1 chk_log("lit_cred_cap", 4, 64'h1111);
    chk("lit_cred_block", 64'(req_ready), 64'(0));
    rd_valid = 1'b1; rd_last = 1'b1; rd_id = 4'b0110; rd_data = 32'hC0DE_0001;
    g_log.delete();
    #1 chk("lit_ret_p1", 64'(ret_valid), 64'b0010);
    chk("lit_ret_sub_p1", 64'(ret_sub_id), 64'd2);
    @(posedge clk); #1 rd_valid = 1'b0; rd_last = 1'b0;
    #1 chk("lit_cred_resume", 64'(req_ready), 64'b0010);
    @(posedge clk); #1 chk_log("lit_cred_one_more", 1, 64'h1);
    chk("lit_cred_reblock", 64'(req_ready), 64'(0));

    // Backpressure: held payload, no accepts
    rst_on();
    all_ports(1'b1, 1'b0);
    rst_off();
    @(posedge clk);
    @(posedge clk); #1 mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("lit_bp_addr", 64'(mem_addr), 64'h2001);
      chk("lit_bp_id", 64'(mem_id), 64'b0101);
      chk("lit_bp_ready", 64'(req_ready), 64'(0));
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    #1 chk("lit_bp_resume", 64'(req_ready), 64'b0100);

    // Same-cycle read accept and rd_last on port 2 at credits=2
    rst_on();
    all_ports(1'b0, 1'b0);
    set_port(2, 1'b1, 1'b1);
    rst_off();
    @(posedge clk);
    @(posedge clk); #1;
    rd_valid = 1'b1; rd_last = 1'b1; rd_id = 4'b1011; rd_data = 32'h5A5A_0002;
    g_log.delete();
    #1 chk("lit_same_ret", 64'(ret_valid), 64'b0100);
    chk("lit_same_sub", 64'(ret_sub_id), 64'd3);
    chk("lit_same_ready", 64'(req_ready), 64'b0100);
    @(posedge clk); #1 rd_valid = 1'b0; rd_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_log("lit_same_cred", 3, 64'h222);
    chk("lit_same_block", 64'(req_ready), 64'(0));

    // Reset mid-traffic with credits outstanding
    set_port(0, 1'b1, 1'b0);
    @(posedge clk); #2 rst = 1'b1;
    #1 chk("lit_mid_rst_mvalid", 64'(mem_valid), 64'(0));
    chk("lit_mid_rst_ready", 64'(req_ready), 64'(0));
    rst_off();
    repeat (10) @(posedge clk);
    #1 chk_log("lit_post_rst", 10, 64'h0202020200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_wrr_arbiter.md
Name: l2_wrr_arbiter

Overview:
- Parametrised successor to the L2 request arbiter. Arbitrates NUM_PORTS requesters onto one L2 memory request channel using weighted round-robin.
- Each port's outstanding reads are capped by a per-port credit counter.
- Read return beats are demultiplexed back to the owning port by transaction ID.
- Sits between the L1/requester side and the L2 memory controller, replacing fixed single-grant round-robin.

Parameters:
NUM_PORTS, 4, number of requester ports (>=2)
SUB_ID_W, 2, per-port transaction sub-ID width
WEIGHT_W, 3, width of each port's weight field
MAX_OUTSTANDING, 4, max read bursts in flight per port (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_PORTS  per-port request valid
req_ready  out  NUM_PORTS  per-port request accepted this cycle
req_addr  in  NUM_PORTS*30  word addresses
req_rnw  in  NUM_PORTS  1=read, 0=write
req_burst  in  NUM_PORTS*5  burst length minus 1
req_sub_id  in  NUM_PORTS*SUB_ID_W  requester sub-IDs
port_weight  in  NUM_PORTS*WEIGHT_W  quasi-static grants-per-turn; 0 treated as 1
mem_valid  out  1  registered request valid
mem_ready  in  1  memory accepts request
mem_addr  out  30  request address
mem_rnw  out  1  request direction
mem_burst  out  5  burst length minus 1
mem_id  out  ID_W  {port index, sub_id}; ID_W = PORT_W+SUB_ID_W, PORT_W = max(1,clog2(NUM_PORTS))
rd_valid  in  1  read return beat
rd_id  in  ID_W  return transaction ID
rd_last  in  1  final beat of burst
rd_data  in  32  return data
ret_valid  out  NUM_PORTS  one-hot return valid
ret_sub_id  out  SUB_ID_W  rd_id sub-ID field, combinational
ret_data  out  32  rd_data, combinational

Behaviour:
- Reset (async, rst=1):
  - mem_valid=0, mem_* payload=0.
  - Pointer=port 0, turn counter=0, all credit counters=0.
  - req_ready=0, ret_valid=0.
- Eligibility: port i is eligible when req_valid[i] & (~req_rnw[i] | credits[i] < MAX_OUTSTANDING).
- Load enable: load = ~mem_valid | mem_ready.
- Grant selection:
  - If the current pointer port is eligible and turn count < its weight, it keeps the grant.
  - Otherwise, grant the first eligible port strictly after the pointer in circular order, wrapping back to the pointer port last.
- Accept: req_ready[g] = load & any_eligible; no other port sees ready.
- On accept:
  - Output register loads the granted payload; mem_valid=1 the next cycle.
  - Latency is 1 cycle from req_valid to mem_valid.
- Turn counter:
  - On accept by the same pointer port: turn+1.
  - On switch: pointer<=g, turn<=1.
  - When turn reaches the weight, the next accept must move to another eligible port if one exists. If none exists, the same port continues and turn resets to 1.
- Backpressure: while mem_valid & ~mem_ready, mem_* are held stable and no accept occurs.
- Without backpressure, throughput is 1 request/cycle.
- Credits:
  - Increment on an accepted read of port i.
  - Decrement on rd_valid & rd_last with rd_id port field = i.
  - If both happen in the same cycle, the counter is unchanged.
  - A decrement at 0 saturates at 0 and fires a simulation assertion.
- Returns:
  - ret_valid[rd_id port] = rd_valid. There is no buffering and no backpressure.
  - A port field >= NUM_PORTS drives no ret_valid and fires an assertion.
- Writes: write data is not handled here; the separate data path owns it. Writes consume no credit.
- Weight changes take effect at the next turn boundary.

Optional Feature:
- Macro: L2_ARB_PERF_COUNTERS_EN.
- With the macro defined:
  - Adds output perf_grants, NUM_PORTS*32: per-port accepted-request counters, wrapping at 2^32.
  - Adds output perf_credit_stalls, NUM_PORTS*32: per-port cycles in which req_valid & req_rnw & credits==MAX_OUTSTANDING.
  - Both counters are cleared by rst.
- Without the macro: these ports and counters do not exist, and arbitration is identical.

Decomposition:
- l2_config_and_types gains:
  - l2_wrr_request_t (addr, rnw, burst, sub_id)
  - l2_wrr_mem_request_t (adds id)
  - PORT_W/ID_W derivation as localparams
- Sub-module l2_wrr_select: combinational circular first-eligible search starting after a given pointer. Outputs grant index and any_eligible.
- Credit counters and the output register stay in the top module.

Test Plan:
- Weights {1,1,1,1}, all ports continuously valid writes, mem_ready=1 -> grants cycle 0,1,2,3,0,… one per cycle; mem_id port field matches.
- Weights {3,1,0,2}, all valid -> grant sequence 0,0,0,1,2,3,3,0,0,0.
- MAX_OUTSTANDING=4, port 1 issues 5 reads with no returns -> 4 accepted, 5th held with req_ready[1]=0. After rd_last for ID {1,x}, the 5th is accepted the next cycle.
- mem_ready=0 for 3 cycles with mem_valid=1 -> mem_addr/mem_id stable, req_ready all 0. Accept resumes the cycle mem_ready=1.
- Same-cycle read accept on port 2 and rd_last for port 2 at credits=2 -> credits stay 2. rd_id={2,3} -> ret_valid=4'b0100, ret_sub_id=3.
- Assert rst mid-burst with mem_valid=1 and credits nonzero -> mem_valid=0 and credits=0 immediately. The first grant after release is to port 0 if eligible.
